// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the EX-stage ALU sharing arbiter.
// ALU opcodes mirror the common pipeline defines.
package alu_share_arbiter_pkg;

   localparam int unsigned AluTypeW = 4;

   localparam logic [AluTypeW-1:0] AluAdd = 4'd0;
   localparam logic [AluTypeW-1:0] AluSub = 4'd1;
   localparam logic [AluTypeW-1:0] AluAnd = 4'd2;
   localparam logic [AluTypeW-1:0] AluOr  = 4'd3;
   localparam logic [AluTypeW-1:0] AluXor = 4'd4;

   typedef enum logic [1:0] {
      StIdle,
      StPend,
      StResp
   } arb_state_e;

   // A zero-width counter is not legal, so STARVE_MAX = 0 still gets one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_starve_counter.sv
// Saturating starvation counter: counts denied pending cycles up to STARVE_MAX.
module alu_share_arbiter_starve_counter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 inc,
   input  logic                                 clr,
   output logic                                 at_max,
   output logic [cnt_width(STARVE_MAX)-1:0]     cnt
);

   localparam int unsigned CntW = cnt_width(STARVE_MAX);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign at_max = (cnt_q == CntW'(STARVE_MAX));
   assign cnt    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !at_max) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares the EX-stage ALU between the pipeline and a one-entry accelerator port,
// using EX bubbles first and a one-cycle forced stall once the request has starved.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned ALU_TYPE_W = AluTypeW
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ex_valid,
   input  logic [ALU_TYPE_W-1:0] ex_alu_type,
   input  logic [31:0]           ex_op1,
   input  logic [31:0]           ex_op2,
   input  logic                  acc_req_valid,
   output logic                  acc_req_ready,
   input  logic [ALU_TYPE_W-1:0] acc_alu_type,
   input  logic [31:0]           acc_op1,
   input  logic [31:0]           acc_op2,
   output logic                  acc_rsp_valid,
   output logic [31:0]           acc_rsp_data,
   input  logic                  acc_rsp_ready,
   output logic [ALU_TYPE_W-1:0] alu_type,
   output logic [31:0]           alu_op1,
   output logic [31:0]           alu_op2,
   input  logic [31:0]           alu_result,
   output logic                  stall_ex,
   output logic                  grant_acc
);

   localparam int unsigned CntW = cnt_width(STARVE_MAX);

   arb_state_e            state_q, state_d;
   logic [ALU_TYPE_W-1:0] buf_type_q;
   logic [31:0]           buf_op1_q, buf_op2_q;
   logic [31:0]           rsp_data_q;
   logic [CntW-1:0]       starve_cnt;
   logic                  at_max;
   logic                  cnt_inc, cnt_clr;
   logic                  req_hs;

   assign req_hs = acc_req_valid && acc_req_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_hs) state_d = StPend;
         StPend:  if (grant_acc) state_d = StResp;
         StResp:  if (acc_rsp_ready) state_d = req_hs ? StPend : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      acc_req_ready = 1'b0;
      acc_rsp_valid = 1'b0;
      grant_acc     = 1'b0;
      stall_ex      = 1'b0;
      unique case (state_q)
         StIdle: acc_req_ready = 1'b1;
         StPend: begin
            grant_acc = !ex_valid || at_max;
            stall_ex  = ex_valid && at_max;
         end
         StResp: begin
            acc_rsp_valid = 1'b1;
            acc_req_ready = acc_rsp_ready;
         end
         default: ;
      endcase
   end

   // Counter only runs while a request is waiting and being denied.
   assign cnt_inc = (state_q == StPend) && ex_valid && !grant_acc;
   assign cnt_clr = (state_q != StPend) || grant_acc;

   alu_share_arbiter_starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_counter (
      .clk    (clk),
      .rstn   (rstn),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .at_max (at_max),
      .cnt    (starve_cnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_type_q <= '0;
         buf_op1_q  <= '0;
         buf_op2_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         if (req_hs) begin
            buf_type_q <= acc_alu_type;
            buf_op1_q  <= acc_op1;
            buf_op2_q  <= acc_op2;
         end
         if (grant_acc) begin
            rsp_data_q <= alu_result;
         end
      end
   end

   assign acc_rsp_data = rsp_data_q;
   assign alu_type     = grant_acc ? buf_type_q : ex_alu_type;
   assign alu_op1      = grant_acc ? buf_op1_q  : ex_op1;
   assign alu_op2      = grant_acc ? buf_op2_q  : ex_op2;

endmodule
